vreg_addr_seq: RTL
==================

// Module: vreg_addr_seq
// PURPOSE
//  Multi-operand vector-register address sequencer. Accepts one instruction's register-group indices
//  (up to NUM_PORTS operands, e.g. vs1/vs2/vd) plus vlmul, and emits one physical register address
//  per operand per beat, LMUL beats per instruction. Uses valid/ready handshakes on both sides, so the
//  VRF read/write stages can stall it. Supports ascending or descending walk order and flush.
// PARAMETERS
//  ADDR_WIDTH  5  physical vector register address width (32 registers)
//  NUM_PORTS   3  operand address channels sequenced in lockstep
// PORTS
//  clk        in   1                      clock; all state updates on posedge
//  rst        in   1                      reset, synchronous, active-low
//  flush      in   1                      abort the current sequence; return to IDLE next edge
//  in_valid   in   1                      request present
//  in_ready   out  1                      request accepted when in_valid & in_ready
//  in_vlmul   in   3                      LMUL code: 0..3 -> 1,2,4,8 registers; 5..7 fractional -> 1; 4 reserved
//  in_port_en in   NUM_PORTS              per-operand enable; disabled ports output 0
//  in_rev     in   1                      1 = walk the group from highest to lowest register
//  in_addr    in   NUM_PORTS*ADDR_WIDTH   group index per port, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//  out_valid  out  1                      beat valid
//  out_ready  in   1                      consumer takes the beat when out_valid & out_ready
//  out_addr   out  NUM_PORTS*ADDR_WIDTH   physical register per port for this beat
//  out_port_en out NUM_PORTS              latched in_port_en
//  out_beat   out  3                      beat index 0..LMUL-1, in emission order
//  out_last   out  1                      final beat of the group
//  err        out  1                      sticky-per-request: reserved vlmul or group overflowed ADDR_WIDTH
// BEHAVIOUR
//  - Reset (rst=0 at posedge): state=IDLE; out_valid=0, out_addr=0, out_port_en=0, out_beat=0,
//    out_last=0, err=0. Reset mid-sequence drops it; no further beats are emitted.
//  - Group size: N = 1<<vlmul for vlmul<=3, else 1. Base b_p = in_addr_p << vlmul (vlmul<=3), else in_addr_p.
//  - Overflow: any bit shifted out of ADDR_WIDTH, or vlmul==4, sets err for that request. The sequence
//    still runs using the truncated base (vlmul==4 treated as N=1). err clears on the next acceptance.
//  - States IDLE/BUSY. IDLE: in_ready=~flush. Accept -> BUSY; first beat has out_valid=1 on the next edge
//    (latency 1). Beat k: addr_p = b_p+k (fwd) or b_p+N-1-k (rev), mod 2^ADDR_WIDTH.
//  - Beat advances only on out_valid&out_ready; otherwise all outputs hold stable (no glitching while stalled).
//  - out_last = (out_beat==N-1). In BUSY, in_ready = out_last & out_ready & ~flush: a back-to-back
//    request issues its first beat in the cycle after the last beat, leaving no bubble. Otherwise -> IDLE
//    and out_valid=0.
//  - flush: highest priority after rst. Next edge: IDLE, out_valid=0, and no request accepted that
//    cycle (in_ready=0). err is held.
//  - N=1: a single beat with out_last=1.
// STRUCTURE
//  - Package vreg_addr_pkg: state enum {IDLE,BUSY}; LMUL codes (LMUL1..LMUL8, LMUL_RSVD=4);
//    function group_size(vlmul).
//  - Sub-module vreg_group_base (combinational, one instance per port): addr, vlmul -> base, ovf.
//    The top holds the FSM, beat counter and output registers.
// TESTING
//  1 vlmul=2, addr={2,1,0}, fwd, out_ready=1 -> 4 beats: port0 0..3, port1 4..7, port2 8..11; last on beat 3.
//  2 Same request with in_rev=1 -> port1 emits 7,6,5,4; out_beat 0..3; err=0.
//  3 vlmul=3, addr0=3; out_ready low for beats 1-2 -> addr 24,25 held stable; 26..31 follow; no beat lost.
//  4 Back-to-back: vlmul=1 then vlmul=0, in_valid held -> beats 2,3 then next base, no idle cycle.
//  5 vlmul=3, addr0=5 -> err=1; addresses 8..15 (truncated base 40 mod 32=8). vlmul=4 -> err=1, single beat.
//  6 flush at beat 2 of 8 -> out_valid=0 next cycle; rst=0 mid-sequence -> all outputs 0; in_ready=1 after.

Source files
------------

// File: rtl/vreg_addr_seq_pkg.sv
// Shared types, LMUL codes and group-size helper for the vector-register address sequencer.
package vreg_addr_pkg;

    localparam int ADDR_WIDTH_DEF = 5;
    localparam int NUM_PORTS_DEF  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [2:0] LMUL1     = 3'd0;
    localparam logic [2:0] LMUL2     = 3'd1;
    localparam logic [2:0] LMUL4     = 3'd2;
    localparam logic [2:0] LMUL8     = 3'd3;
    localparam logic [2:0] LMUL_RSVD = 3'd4;

    // Reserved and fractional codes all collapse to a single-register group.
    function automatic logic [3:0] group_size(input logic [2:0] vlmul);
        return (vlmul <= LMUL8) ? (4'd1 << vlmul) : 4'd1;
    endfunction

endpackage

// File: rtl/vreg_addr_seq_if.sv
// Request and beat handshake bundle between an issuing stage and the address sequencer.
interface vreg_addr_seq_if
    import vreg_addr_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_PORTS  = NUM_PORTS_DEF
);
    logic                            in_valid;
    logic                            in_ready;
    logic [2:0]                      in_vlmul;
    logic [NUM_PORTS-1:0]            in_port_en;
    logic                            in_rev;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] in_addr;
    logic                            out_valid;
    logic                            out_ready;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] out_addr;
    logic [NUM_PORTS-1:0]            out_port_en;
    logic [2:0]                      out_beat;
    logic                            out_last;
    logic                            err;

    modport master (
        output in_valid, in_vlmul, in_port_en, in_rev, in_addr, out_ready,
        input  in_ready, out_valid, out_addr, out_port_en, out_beat, out_last, err
    );

    modport slave (
        input  in_valid, in_vlmul, in_port_en, in_rev, in_addr, out_ready,
        output in_ready, out_valid, out_addr, out_port_en, out_beat, out_last, err
    );

endinterface

// File: rtl/vreg_addr_seq_group_base.sv
// Scales one register-group index to its first physical register and flags bits lost off the top.
module vreg_group_base
    import vreg_addr_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            vlmul,
    output logic [ADDR_WIDTH-1:0] base,
    output logic                  ovf
);

    logic [ADDR_WIDTH+2:0] wide;

    always_comb begin
        wide = {3'b000, addr} << ((vlmul <= LMUL8) ? vlmul : 3'd0);
        base = wide[ADDR_WIDTH-1:0];
        ovf  = |wide[ADDR_WIDTH+2:ADDR_WIDTH];
    end

endmodule

// File: rtl/vreg_addr_seq.sv
// Emits one physical register address per operand per beat, LMUL beats per accepted request,
// with stall-safe registered outputs, reverse walk, flush and back-to-back issue.
module vreg_addr_seq
    import vreg_addr_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_PORTS  = NUM_PORTS_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    vreg_addr_seq_if.slave  bus
);

    state_t                          state;
    logic [ADDR_WIDTH-1:0]           base_q [NUM_PORTS];
    logic [2:0]                      last_beat_q;
    logic                            rev_q;

    logic [ADDR_WIDTH-1:0]           base_w [NUM_PORTS];
    logic [NUM_PORTS-1:0]            ovf_w;
    logic                            accept;
    logic                            advance;
    logic                            err_w;
    logic [2:0]                      sel_last;
    logic [2:0]                      sel_beat;
    logic [2:0]                      offset;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] next_addr;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_base
        vreg_group_base #(.ADDR_WIDTH(ADDR_WIDTH)) u_base (
            .addr  (bus.in_addr[p*ADDR_WIDTH +: ADDR_WIDTH]),
            .vlmul (bus.in_vlmul),
            .base  (base_w[p]),
            .ovf   (ovf_w[p])
        );
    end

    // A new request may only enter as the previous group's last beat leaves.
    always_comb begin
        if (state == IDLE) bus.in_ready = ~flush;
        else               bus.in_ready = bus.out_last & bus.out_ready & ~flush;
    end

    assign accept  = bus.in_valid & bus.in_ready;
    assign advance = bus.out_valid & bus.out_ready;
    assign err_w   = (|(ovf_w & bus.in_port_en)) | (bus.in_vlmul == LMUL_RSVD);

    // One shared address path: beat 0 of a fresh request, or the next beat of the held one.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch can be inferred.
        next_addr = '0;
        sel_last  = accept ? 3'(group_size(bus.in_vlmul) - 4'd1) : last_beat_q;
        sel_beat  = accept ? 3'd0 : bus.out_beat + 3'd1;
        offset    = (accept ? bus.in_rev : rev_q) ? (sel_last - sel_beat) : sel_beat;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (accept ? bus.in_port_en[p] : bus.out_port_en[p]) begin
                next_addr[p*ADDR_WIDTH +: ADDR_WIDTH] =
                    (accept ? base_w[p] : base_q[p]) + ADDR_WIDTH'(offset);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= IDLE;
            bus.out_valid   <= 1'b0;
            bus.out_addr    <= '0;
            bus.out_port_en <= '0;
            bus.out_beat    <= 3'd0;
            bus.out_last    <= 1'b0;
            bus.err         <= 1'b0;
            // NOTE: base_q is a handful of flops, not a RAM, so resetting it costs nothing and avoids X.
            base_q          <= '{default: '0};
            last_beat_q     <= 3'd0;
            rev_q           <= 1'b0;
        end else if (flush) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
        end else if (accept) begin
            state           <= BUSY;
            bus.out_valid   <= 1'b1;
            bus.out_addr    <= next_addr;
            bus.out_port_en <= bus.in_port_en;
            bus.out_beat    <= 3'd0;
            bus.out_last    <= (sel_last == 3'd0);
            bus.err         <= err_w;
            base_q          <= base_w;
            last_beat_q     <= sel_last;
            rev_q           <= bus.in_rev;
        end else if (advance) begin
            if (bus.out_last) begin
                state         <= IDLE;
                bus.out_valid <= 1'b0;
                bus.out_last  <= 1'b0;
            end else begin
                bus.out_beat <= sel_beat;
                bus.out_addr <= next_addr;
                bus.out_last <= (sel_beat == last_beat_q);
            end
        end
    end

endmodule
